ctrl_seq: RTL



---
 rtl/ctrl_seq_if.sv | 38 +++
 rtl/ctrl_seq.sv | 100 ++++++++++
 2 files changed

// File: rtl/ctrl_seq_if.sv
// Sequencer bus: program-memory handshake, ALU carry/resume inputs, and the
// strobes and decoded fields that drive the pc and reg_alu blocks.
interface ctrl_seq_if #(
   parameter int IW  = 16,
   parameter int RAW = 3,
   parameter int OPW = 2,
   parameter int AW  = 7,
   parameter int CW  = 16
);
   logic [IW-1:0]  d_in;
   logic           mem_ready;
   logic           cout;
   logic           resume;
   logic           load_ir;
   logic           pc_inc;
   logic           pc_load;
   logic [AW-1:0]  jump_addr;
   logic           wr_reg;
   logic [RAW-1:0] rd_addr_a;
   logic [RAW-1:0] rd_addr_b;
   logic [RAW-1:0] wr_addr;
   logic [OPW-1:0] op;
   logic           halted;
   logic           illegal;
   logic [CW-1:0]  retired;

   modport master (
      input  d_in, mem_ready, cout, resume,
      output load_ir, pc_inc, pc_load, jump_addr, wr_reg,
             rd_addr_a, rd_addr_b, wr_addr, op, halted, illegal, retired
   );

   modport slave (
      output d_in, mem_ready, cout, resume,
      input  load_ir, pc_inc, pc_load, jump_addr, wr_reg,
             rd_addr_a, rd_addr_b, wr_addr, op, halted, illegal, retired
   );
endinterface

// File: rtl/ctrl_seq.sv
// Instruction sequencer: FETCH/EXEC/HALT control with wait-state fetch,
// jump/jump-if-carry decode, sticky illegal flag and retired counter.
module ctrl_seq #(
   parameter int IW  = 16,
   parameter int RAW = 3,
   parameter int OPW = 2,
   parameter int AW  = 7,
   parameter int CW  = 16
) (
   input  logic         clk,
   input  logic         reset,
   ctrl_seq_if.master   bus
);
   localparam int CLW = IW - 3*RAW - OPW;
   localparam logic [CLW-1:0] CLS_ALU  = CLW'(0);
   localparam logic [CLW-1:0] CLS_JC   = CLW'(1);
   localparam logic [CLW-1:0] CLS_JMP  = CLW'(2);
   localparam logic [CLW-1:0] CLS_NOP  = CLW'(3);
   localparam logic [CLW-1:0] CLS_HALT = CLW'(4);

   typedef enum logic [1:0] {S_FETCH, S_EXEC, S_HALT} state_t;

   state_t         r_state, w_next;
   logic [IW-1:0]  r_ir;
   logic           r_illegal;
   logic [CW-1:0]  r_retired;
   logic [CLW-1:0] w_cls;
   logic           w_load_ir, w_pc_inc, w_pc_load, w_wr_reg;

   assign w_cls = r_ir[IW-1:3*RAW+OPW];

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state   <= S_FETCH;
         r_ir      <= '0;
         r_illegal <= 1'b0;
         r_retired <= '0;
      end else begin
         r_state <= w_next;
         if (r_state == S_FETCH && bus.mem_ready)
            r_ir <= bus.d_in;
         if (r_state == S_EXEC) begin
            r_retired <= r_retired + CW'(1);
            if (w_cls > CLS_HALT)
               r_illegal <= 1'b1;
         end
      end
   end

   always_comb begin
      w_next    = r_state;
      w_load_ir = 1'b0;
      w_pc_inc  = 1'b0;
      w_pc_load = 1'b0;
      w_wr_reg  = 1'b0;
      case (r_state)
         S_FETCH: begin
            w_load_ir = 1'b1;
            if (bus.mem_ready)
               w_next = S_EXEC;
         end
         S_EXEC: begin
            w_next = (w_cls == CLS_HALT) ? S_HALT : S_FETCH;
            case (w_cls)
               CLS_ALU: begin
                  w_wr_reg = 1'b1;
                  w_pc_inc = 1'b1;
               end
               CLS_JC: begin
                  w_pc_load = bus.cout;
                  w_pc_inc  = ~bus.cout;
               end
               CLS_JMP:  w_pc_load = 1'b1;
               CLS_NOP:  w_pc_inc  = 1'b1;
               // HALT still advances pc so resume continues past it
               CLS_HALT: w_pc_inc  = 1'b1;
               default:  w_pc_inc  = 1'b1;
            endcase
         end
         S_HALT: begin
            if (bus.resume)
               w_next = S_FETCH;
         end
         default: w_next = S_FETCH;
      endcase
   end

   assign bus.load_ir   = w_load_ir;
   assign bus.pc_inc    = w_pc_inc;
   assign bus.pc_load   = w_pc_load;
   assign bus.wr_reg    = w_wr_reg;
   assign bus.halted    = (r_state == S_HALT);
   assign bus.illegal   = r_illegal;
   assign bus.retired   = r_retired;
   assign bus.jump_addr = r_ir[AW-1:0];
   assign bus.rd_addr_a = r_ir[RAW-1:0];
   assign bus.rd_addr_b = r_ir[2*RAW-1:RAW];
   assign bus.wr_addr   = r_ir[3*RAW-1:2*RAW];
   assign bus.op        = r_ir[3*RAW+OPW-1:3*RAW];
endmodule
